// File: rtl/mult_sequencer.sv
// mult_sequencer: issuing-side driver for the 8x8 shift-add multiplier controller.
//
// It accepts an operand pair on a valid/ready request port and holds the operands on the
// datapath inputs. It then issues a one-cycle start pulse followed by the count sequence
// 00,01,10,11 and waits for done. The product is returned on a valid/ready response port.
// If the controller reports ERR, or done does not arrive in time, the run is retried up to
// MAX_RETRY times before an error response is returned.
//
// Optional build macro: MULT_SEQ_ZERO_BYPASS_EN. When it is defined, a request with a zero
// operand is answered directly with product 0, and the controller is never started.
//
// Ports:
//   clk, reset_a                    clock; asynchronous active-low reset
//   req_valid/req_ready/req_a/req_b request handshake and operands
//   op_a, op_b                      registered operands to the datapath
//   mult_start, mult_count          registered start/count to the controller
//   mult_done, mult_state           done and state_out from the controller (3'b101 = ERR)
//   mult_product                    accumulator output of the datapath
//   rsp_valid/rsp_ready             response handshake
//   rsp_product, rsp_err            result and failure flag
//   busy                            high in every state except idle
module mult_sequencer #(
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned DONE_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic        mult_start,
  output logic [1:0]  mult_count,
  input  logic        mult_done,
  input  logic [2:0]  mult_state,
  input  logic [15:0] mult_product,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_product,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StLoad, StStep, StWaitDone, StResp} state_e;

  localparam logic [2:0] ErrState = 3'b101;
  localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);
  localparam logic [3:0] TmoLast  = 4'(DONE_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [2:0]  retry_q, retry_d;
  logic [3:0]  tmo_q, tmo_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic        start_q, start_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] product_q, product_d;
  logic        err_q, err_d;
  logic        run_fail;
  logic        zero_bypass;
  logic        ctl_err;

  assign ctl_err = (mult_state == ErrState);

`ifdef MULT_SEQ_ZERO_BYPASS_EN
  assign zero_bypass = (req_a == 8'h00) || (req_b == 8'h00);
`else
  assign zero_bypass = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    start_d   = 1'b0;
    count_d   = count_q;
    product_d = product_q;
    err_d     = err_q;
    run_fail  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_a_d  = req_a;
          op_b_d  = req_b;
          retry_d = 3'd0;
          if (zero_bypass) begin
            state_d   = StResp;
            product_d = 16'h0000;
            err_d     = 1'b0;
          end else begin
            // Start/count are registered, so they are set here to be visible during LOAD.
            state_d = StLoad;
            start_d = 1'b1;
            count_d = 2'b00;
          end
        end
      end
      StLoad: begin
        state_d = StStep;
        step_d  = 2'd0;
        count_d = 2'b00;
      end
      StStep: begin
        if (ctl_err) begin
          run_fail = 1'b1;
        end else if (step_q == 2'd3) begin
          state_d = StWaitDone;
          tmo_d   = 4'd0;
        end else begin
          step_d  = step_q + 2'd1;
          count_d = step_q + 2'd1;
        end
      end
      StWaitDone: begin
        // Done takes priority over a simultaneous ERR.
        if (mult_done) begin
          state_d   = StResp;
          product_d = mult_product;
          err_d     = 1'b0;
        end else if (ctl_err || (tmo_q == TmoLast)) begin
          run_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (run_fail) begin
      if (retry_q < MaxRetry) begin
        // A fresh start pulse also pulls the controller out of ERR.
        retry_d = retry_q + 3'd1;
        state_d = StLoad;
        start_d = 1'b1;
        count_d = 2'b00;
      end else begin
        state_d   = StResp;
        product_d = 16'h0000;
        err_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q   <= StIdle;
      step_q    <= 2'd0;
      retry_q   <= 3'd0;
      tmo_q     <= 4'd0;
      op_a_q    <= 8'h00;
      op_b_q    <= 8'h00;
      start_q   <= 1'b0;
      count_q   <= 2'b00;
      product_q <= 16'h0000;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      start_q   <= start_d;
      count_q   <= count_d;
      product_q <= product_d;
      err_q     <= err_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign mult_start  = start_q;
  assign mult_count  = count_q;
  assign rsp_product = product_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a small controller/datapath model:
// done pulses one cycle after the count steps 10 -> 11, the product is op_a*op_b,
// and ERR on mult_state is forced from the stimulus.
module tb_mult_sequencer;

  logic        clk;
  logic        reset_a;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        mult_start;
  logic [1:0]  mult_count;
  logic        mult_done;
  logic [2:0]  mult_state;
  logic [15:0] mult_product;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_product;
  logic        rsp_err;
  logic        busy;

  logic        done_en;
  logic        err_force;
  logic [1:0]  prev_count;
  logic        done_q;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  int st;

  mult_sequencer #(
    .MAX_RETRY    (2),
    .DONE_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset_a      (reset_a),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .op_a         (op_a),
    .op_b         (op_b),
    .mult_start   (mult_start),
    .mult_count   (mult_count),
    .mult_done    (mult_done),
    .mult_state   (mult_state),
    .mult_product (mult_product),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_product  (rsp_product),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller/datapath model.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      prev_count <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      prev_count <= mult_count;
      done_q     <= done_en && (mult_count == 2'b11) && (prev_count == 2'b10);
    end
  end

  assign mult_done    = done_q;
  assign mult_product = 16'(op_a) * 16'(op_b);
  assign mult_state   = err_force ? 3'b101 : 3'b000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits up to max cycles for rsp_valid, counting start pulses seen on the way.
  task automatic wait_rsp(input int max, output int cycles, output int starts);
    cycles = 0;
    starts = 0;
    while (rsp_valid !== 1'b1 && cycles < max) begin
      if (mult_start === 1'b1) starts++;
      tick();
      cycles++;
    end
  endtask

  initial begin
    reset_a   = 1'b0;
    req_valid = 1'b0;
    req_a     = 8'h00;
    req_b     = 8'h00;
    rsp_ready = 1'b0;
    done_en   = 1'b1;
    err_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 16'(req_ready), 16'h1);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_start", 16'(mult_start), 16'h0);
    check("rst_count", 16'(mult_count), 16'h0);
    check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    check("rst_product", rsp_product, 16'h0000);
    check("rst_err", 16'(rsp_err), 16'h0);
    check("rst_op_a", 16'(op_a), 16'h00);
    reset_a = 1'b1;
    tick();

    // 1: nominal 0xFF*0xFF, cycle by cycle.
    req_a = 8'hFF; req_b = 8'hFF; req_valid = 1'b1; rsp_ready = 1'b1;
    check("t1_req_ready", 16'(req_ready), 16'h1);
    tick();
    req_valid = 1'b0;
    check("t1_load_start", 16'(mult_start), 16'h1);
    check("t1_load_count", 16'(mult_count), 16'h0);
    check("t1_busy", 16'(busy), 16'h1);
    check("t1_req_ready_busy", 16'(req_ready), 16'h0);
    check("t1_op_a", 16'(op_a), 16'h00FF);
    tick();
    check("t1_s0_start", 16'(mult_start), 16'h0);
    check("t1_s0_count", 16'(mult_count), 16'h0);
    tick();
    check("t1_s1_count", 16'(mult_count), 16'h1);
    tick();
    check("t1_s2_count", 16'(mult_count), 16'h2);
    tick();
    check("t1_s3_count", 16'(mult_count), 16'h3);
    tick();
    check("t1_wait_valid", 16'(rsp_valid), 16'h0);
    check("t1_wait_count", 16'(mult_count), 16'h3);
    tick();
    check("t1_rsp_valid", 16'(rsp_valid), 16'h1);
    check("t1_product", rsp_product, 16'hFE01);
    check("t1_err", 16'(rsp_err), 16'h0);
    tick();
    check("t1_valid_drop", 16'(rsp_valid), 16'h0);
    check("t1_idle_ready", 16'(req_ready), 16'h1);
    check("t1_idle_busy", 16'(busy), 16'h0);

    // 2: backpressure 0x12*0x34, with a competing request held during RESP.
    rsp_ready = 1'b0;
    req_a = 8'h12; req_b = 8'h34; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp(20, cyc, st);
    check("t2_latency", 16'(cyc), 16'd6);
    check("t2_starts", 16'(st), 16'd1);
    req_a = 8'h55; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 16'(rsp_valid), 16'h1);
      check("t2_hold_product", rsp_product, 16'h03A8);
      check("t2_hold_ready", 16'(req_ready), 16'h0);
      tick();
    end
    rsp_ready = 1'b1;
    check("t2_op_a_stable", 16'(op_a), 16'h0012);
    tick();
    req_valid = 1'b0;
    check("t2_valid_drop", 16'(rsp_valid), 16'h0);
    check("t2_ready_back", 16'(req_ready), 16'h1);
    check("t2_op_a_kept", 16'(op_a), 16'h0012);
    tick();

    // 3: one ERR cycle during STEP, then a clean retry of 0xA5*0x3C.
    req_a = 8'hA5; req_b = 8'h3C; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    err_force = 1'b1;
    tick();
    err_force = 1'b0;
    check("t3_retry_start", 16'(mult_start), 16'h1);
    check("t3_retry_count", 16'(mult_count), 16'h0);
    wait_rsp(20, cyc, st);
    check("t3_latency", 16'(cyc), 16'd6);
    check("t3_starts", 16'(st), 16'd1);
    check("t3_product", rsp_product, 16'h26AC);
    check("t3_err", 16'(rsp_err), 16'h0);
    tick();

    // 4: done never arrives; three runs then an error response.
    done_en = 1'b0;
    req_a = 8'h11; req_b = 8'h22; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp(60, cyc, st);
    check("t4_latency", 16'(cyc), 16'd27);
    check("t4_starts", 16'(st), 16'd3);
    check("t4_err", 16'(rsp_err), 16'h1);
    check("t4_product", rsp_product, 16'h0000);
    tick();
    done_en = 1'b1;

    // 5: asynchronous reset during STEP index 10, then a normal job.
    req_a = 8'h03; req_b = 8'h04; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t5_pre_count", 16'(mult_count), 16'h2);
    #2 reset_a = 1'b0;
    #1;
    check("t5_rst_busy", 16'(busy), 16'h0);
    check("t5_rst_ready", 16'(req_ready), 16'h1);
    check("t5_rst_count", 16'(mult_count), 16'h0);
    check("t5_rst_op_a", 16'(op_a), 16'h00);
    check("t5_rst_op_b", 16'(op_b), 16'h00);
    check("t5_rst_product", rsp_product, 16'h0000);
    tick();
    reset_a = 1'b1;
    req_a = 8'h07; req_b = 8'h09; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp(20, cyc, st);
    check("t5_latency", 16'(cyc), 16'd6);
    check("t5_product", rsp_product, 16'h003F);
    tick();

    // 6: zero operand.
    req_a = 8'h00; req_b = 8'h5A; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp(20, cyc, st);
`ifdef MULT_SEQ_ZERO_BYPASS_EN
    check("t6_latency", 16'(cyc), 16'd0);
    check("t6_starts", 16'(st), 16'd0);
`else
    check("t6_latency", 16'(cyc), 16'd6);
    check("t6_starts", 16'(st), 16'd1);
`endif
    check("t6_valid", 16'(rsp_valid), 16'h1);
    check("t6_product", rsp_product, 16'h0000);
    check("t6_err", 16'(rsp_err), 16'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
Issuing-side driver for the 8x8 shift-add multiplier control FSM. It accepts an operand pair on a valid/ready request port and holds the operands on the datapath inputs. It then drives the controller's start/count protocol: a one-cycle start pulse, then count 00,01,10,11 on consecutive cycles. It waits for done, captures the 16-bit product and returns it on a valid/ready response port, retrying when the controller falls into its error state.

Parameters:
MAX_RETRY, 2, retry attempts after the first failed run before reporting an error (0..7).
DONE_TIMEOUT, 4, cycles waited in WAIT_DONE for mult_done before the run is declared failed (1..15).

Ports:
clk  in  1  clock, all logic on rising edge
reset_a  in  1  asynchronous active-low reset
req_valid  in  1  operand pair valid
req_ready  out  1  sequencer can accept a request
req_a  in  8  multiplicand
req_b  in  8  multiplier
op_a  out  8  registered operand A to datapath, stable for the whole run
op_b  out  8  registered operand B to datapath, stable for the whole run
mult_start  out  1  start to controller, registered
mult_count  out  2  count to controller, registered
mult_done  in  1  done from controller
mult_state  in  3  controller state_out; 3'b101 = ERR
mult_product  in  16  accumulator output of datapath
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_product  out  16  product (0 when rsp_err=1)
rsp_err  out  1  run failed after all retries
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset_a=0, async) forces: state IDLE, req_ready=1, op_a=op_b=0, mult_start=0, mult_count=00, rsp_valid=0, rsp_product=0, rsp_err=0, busy=0, retry and timeout counters=0. Reset mid-run aborts without a response.
- States: IDLE, LOAD, STEP, WAIT_DONE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch op_a/op_b, clear retry count and go to LOAD.
- LOAD (1 cycle): mult_start=1, mult_count=00. Go to STEP with step index 0.
- STEP (4 cycles): mult_start=0, mult_count = step index (00,01,10,11). After index 11, go to WAIT_DONE and clear the timeout counter.
- WAIT_DONE: mult_start=0, mult_count holds 11.
  - mult_done=1: capture rsp_product=mult_product, set rsp_err=0, go to RESP.
  - Otherwise, increment the timeout counter.
  - When the counter reaches DONE_TIMEOUT, the run fails.
- Run failure occurs when mult_state==3'b101 in any cycle of STEP or WAIT_DONE, or on timeout.
  - If retry count < MAX_RETRY: increment the retry count and go to LOAD. The start pulse returns the controller from ERR to LSB.
  - Otherwise: set rsp_product=0 and rsp_err=1, then go to RESP.
- RESP: rsp_valid=1 and the outputs are held stable until rsp_ready=1, then go to IDLE. rsp_valid drops on the cycle after acceptance.
- req_ready=0 outside IDLE. Requests are not accepted in the same cycle a response is accepted, so there is a minimum of 1 idle cycle between jobs.
- Nominal latency: request accept to rsp_valid is 7 cycles (LOAD 1 + STEP 4 + done 1 + capture 1).
- op_a/op_b change only on request acceptance in IDLE.
- If mult_done and ERR are seen in the same cycle, done wins.

Optional Feature:
MULT_SEQ_ZERO_BYPASS_EN
- Defined: if req_a==0 or req_b==0 at acceptance, go straight to RESP with rsp_product=0 and rsp_err=0. The controller is never started, so mult_start stays 0. Latency is 1 cycle.
- Undefined: every request runs the full LOAD/STEP/WAIT_DONE sequence, including zero operands.

Test Plan:
1. Nominal run: a=0xFF, b=0xFF with a model controller and datapath → mult_start pulses once; mult_count sequence 00,00,01,10,11; rsp_valid 7 cycles after accept; rsp_product=0xFE01; rsp_err=0.
2. Backpressure: a=0x12, b=0x34, rsp_ready held low 5 cycles → rsp_valid and rsp_product=0x03A8 stable throughout; req_ready=0 until the cycle after acceptance.
3. Single ERR then recover: model forces mult_state=101 once during STEP → a second start pulse is seen; rsp_product correct; rsp_err=0.
4. Persistent failure: mult_done never asserted, MAX_RETRY=2 → exactly 3 start pulses, each run ending after DONE_TIMEOUT cycles in WAIT_DONE; response has rsp_err=1 and rsp_product=0.
5. Reset mid-run: assert reset_a=0 during STEP index 10 → all outputs return to reset values immediately; the next request completes normally.
6. Zero operand: a=0x00, b=0x5A → with the macro defined, no mult_start and rsp_product=0 after 1 cycle; without the macro, the full run occurs and rsp_product=0.
